vga_scan_out: RTL and testbench

Parametrised VGA scan-out engine, successor to the fixed 640x480 framebuffer scanner. Generates programmable horizontal/vertical timing with selectable sync polarity. Produces framebuffer read addresses with integer pixel replication (1x/2x/4x/...) and compensates a configurable framebuffer read latency so that colour, syncs and blanking leave the block cycle-aligned. Sits between the framebuffer BRAM read port and the VGA DAC pins, clocked at pixel rate.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_scan_out.sv | 115 +++++++++++
 tb/tb_vga_scan_out.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the control-pipe payload type.
package vga_pkg;

    localparam int unsigned BPP_DEF       = 3;
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam bit          HSYNC_HIGH_DEF = 1'b0;
    localparam bit          VSYNC_HIGH_DEF = 1'b0;

    // Raw (active-asserted) control flags travelling alongside the framebuffer read.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic frame_start;
    } ctrl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register; DEPTH of 0 is a plain wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ rst;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: programmable timing, replicated framebuffer addressing and
// read-latency-compensated colour/sync outputs.
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int unsigned BITS_PER_PIXEL    = BPP_DEF,
    parameter int unsigned H_VISIBLE         = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT           = H_FRONT_DEF,
    parameter int unsigned H_SYNC            = H_SYNC_DEF,
    parameter int unsigned H_BACK            = H_BACK_DEF,
    parameter int unsigned V_VISIBLE         = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT           = V_FRONT_DEF,
    parameter int unsigned V_SYNC            = V_SYNC_DEF,
    parameter int unsigned V_BACK            = V_BACK_DEF,
    parameter bit          HSYNC_ACTIVE_HIGH = HSYNC_HIGH_DEF,
    parameter bit          VSYNC_ACTIVE_HIGH = VSYNC_HIGH_DEF,
    parameter int unsigned SCALE_SHIFT       = 0,
    parameter int unsigned FB_READ_LATENCY   = 1,
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned FB_W      = H_VISIBLE >> SCALE_SHIFT,
    localparam int unsigned FB_H      = V_VISIBLE >> SCALE_SHIFT,
    localparam int unsigned FB_PIXELS = FB_W * FB_H,
    localparam int unsigned ADDR_W    = (FB_PIXELS > 1) ? $clog2(FB_PIXELS) : 1
) (
    input  logic                      clk,
    input  logic                      i_Reset,
    input  logic [BITS_PER_PIXEL-1:0] i_Fb_Read_Data,
    output logic [ADDR_W-1:0]         o_Fb_Read_Addr,
    output logic                      o_Fb_Read_En,
    output logic [BITS_PER_PIXEL-1:0] o_RGB,
    output logic                      o_Horizontal_Sync,
    output logic                      o_Vertical_Sync,
    output logic                      o_Visible,
    output logic                      o_Frame_Start
);

    localparam int unsigned HCNT_W = $clog2(H_TOTAL + 1);
    localparam int unsigned VCNT_W = $clog2(V_TOTAL + 1);
    localparam logic [VCNT_W-1:0] ROW_MASK = VCNT_W'((1 << SCALE_SHIFT) - 1);

    logic [HCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
    logic [ADDR_W-1:0] row_base;
    logic              h_last, v_last, h_vis, v_vis, row_step;
    ctrl_t             ctrl_raw, ctrl_d;

    assign h_last   = (h == HCNT_W'(H_TOTAL - 1));
    assign v_last   = (v == VCNT_W'(V_TOTAL - 1));
    assign h_vis    = (h < HCNT_W'(H_VISIBLE));
    assign v_vis    = (v < VCNT_W'(V_VISIBLE));
    // Advance the row base only after the last replicated copy of a framebuffer row.
    assign row_step = v_vis && ((v & ROW_MASK) == ROW_MASK);

    // Scan counters and incremental row base address.
    always_ff @(posedge clk) begin
        if (i_Reset) begin
            h        <= '0;
            v        <= '0;
            row_base <= '0;
        end else if (h_last) begin
            h <= '0;
            if (v_last) begin
                v        <= '0;
                row_base <= '0;
            end else begin
                v <= v + VCNT_W'(1);
                if (row_step) row_base <= row_base + ADDR_W'(FB_W);
            end
        end else begin
            h <= h + HCNT_W'(1);
        end
    end

    assign o_Fb_Read_En   = h_vis && v_vis;
    assign o_Fb_Read_Addr = o_Fb_Read_En ? (row_base + ADDR_W'(h >> SCALE_SHIFT)) : '0;

    always_comb begin
        ctrl_raw             = '0;
        ctrl_raw.visible     = o_Fb_Read_En;
        ctrl_raw.hsync       = (h >= HCNT_W'(H_VISIBLE + H_FRONT)) &&
                               (h <  HCNT_W'(H_VISIBLE + H_FRONT + H_SYNC));
        ctrl_raw.vsync       = (v >= VCNT_W'(V_VISIBLE + V_FRONT)) &&
                               (v <  VCNT_W'(V_VISIBLE + V_FRONT + V_SYNC));
        ctrl_raw.frame_start = (h == '0) && (v == '0);
    end

    vga_delay_line #(
        .WIDTH ($bits(ctrl_t)),
        .DEPTH (FB_READ_LATENCY)
    ) u_ctrl_delay (
        .clk  (clk),
        .rst  (i_Reset),
        .din  (ctrl_raw),
        .dout (ctrl_d)
    );

    // Output register: control and framebuffer data meet on the same edge.
    always_ff @(posedge clk) begin
        if (i_Reset) begin
            o_RGB             <= '0;
            o_Visible         <= 1'b0;
            o_Frame_Start     <= 1'b0;
            o_Horizontal_Sync <= ~HSYNC_ACTIVE_HIGH;
            o_Vertical_Sync   <= ~VSYNC_ACTIVE_HIGH;
        end else begin
            o_RGB             <= ctrl_d.visible ? i_Fb_Read_Data : '0;
            o_Visible         <= ctrl_d.visible;
            o_Frame_Start     <= ctrl_d.frame_start;
            o_Horizontal_Sync <= ctrl_d.hsync ^ ~HSYNC_ACTIVE_HIGH;
            o_Vertical_Sync   <= ctrl_d.vsync ^ ~VSYNC_ACTIVE_HIGH;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out: two small-timing instances (1x/LAT0/active-high
// and 2x/LAT3/active-low) checked cycle by cycle against an absolute-position model.
module tb_vga_scan_out;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       vis;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S     = (g == 0) ? 0 : 1;
        localparam int LAT   = (g == 0) ? 0 : 3;
        localparam bit HA    = (g == 0);
        localparam bit VA    = (g == 0);
        localparam int D     = LAT + 1;
        localparam int FBW   = HV >> S;
        localparam int AW    = (g == 0) ? 7 : 5;
        localparam int LAST_ADDR  = (g == 0) ? 127 : 31;
        localparam int LINE2_ADDR = (g == 0) ? 32 : 8;

        logic [AW-1:0] addr;
        logic          en, hs, vs, vis, fs;
        logic [2:0]    rgb, rd;
        int            mh = 0;
        int            mv = 0;

        vga_scan_out #(
            .BITS_PER_PIXEL    (3),
            .H_VISIBLE         (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
            .V_VISIBLE         (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
            .HSYNC_ACTIVE_HIGH (HA),
            .VSYNC_ACTIVE_HIGH (VA),
            .SCALE_SHIFT       (S),
            .FB_READ_LATENCY   (LAT)
        ) u_dut (
            .clk               (clk),
            .i_Reset           (rst),
            .i_Fb_Read_Data    (rd),
            .o_Fb_Read_Addr    (addr),
            .o_Fb_Read_En      (en),
            .o_RGB             (rgb),
            .o_Horizontal_Sync (hs),
            .o_Vertical_Sync   (vs),
            .o_Visible         (vis),
            .o_Frame_Start     (fs)
        );

        // Model RAM returns addr[2:0] after LAT cycles.
        if (LAT == 0) begin : g_ram0
            assign rd = addr[2:0];
        end else begin : g_ram
            logic [2:0] pipe [LAT];
            always @(posedge clk) begin
                pipe[0] <= addr[2:0];
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign rd = pipe[LAT-1];
        end

        function automatic exp_t idle_exp();
            exp_t e;
            e = '0;
            e.hs = !HA;
            e.vs = !VA;
            return e;
        endfunction

        function automatic int model_addr(input int h, input int v);
            return (v >> S) * FBW + (h >> S);
        endfunction

        function automatic exp_t model(input int h, input int v);
            exp_t e;
            logic vl;
            vl    = (h < HV) && (v < VV);
            e.vis = vl;
            e.rgb = vl ? 3'(model_addr(h, v)) : 3'd0;
            e.hs  = ((h >= HV + HF) && (h < HV + HF + HS)) ^ !HA;
            e.vs  = ((v >= VV + VF) && (v < VV + VF + VS)) ^ !VA;
            e.fs  = (h == 0) && (v == 0);
            return e;
        endfunction

        initial begin : mon
            exp_t q[$];
            exp_t e;
            bit   armed, rst_prev, have_start, vl;
            int   len, hs_n, vs_n;
            armed = 0; rst_prev = 0; have_start = 0;
            len = 0; hs_n = 0; vs_n = 0;
            forever begin
                @(negedge clk);
                // rst changes only just after posedge, so last negedge's value is what the DUT sampled.
                if (rst_prev) begin
                    mh = 0; mv = 0;
                    q.delete();
                    for (int i = 0; i < D; i++) q.push_back(idle_exp());
                    armed = 1;
                    have_start = 0;
                end else if (armed) begin
                    if (mh == HT - 1) begin
                        mh = 0;
                        mv = (mv == VT - 1) ? 0 : mv + 1;
                    end else begin
                        mh = mh + 1;
                    end
                end
                rst_prev = rst;
                if (armed) begin
                    vl = (mh < HV) && (mv < VV);
                    q.push_back(model(mh, mv));
                    chk($sformatf("g%0d_en", g), int'(en), int'(vl));
                    chk($sformatf("g%0d_addr", g), int'(addr), vl ? model_addr(mh, mv) : 0);
                    if (mh == HV - 1 && mv == VV - 1)
                        chk($sformatf("g%0d_last_addr", g), int'(addr), LAST_ADDR);
                    if (mh == 0 && mv == 2)
                        chk($sformatf("g%0d_line2_addr", g), int'(addr), LINE2_ADDR);
                    e = q.pop_front();
                    chk($sformatf("g%0d_rgb", g), int'(rgb), int'(e.rgb));
                    chk($sformatf("g%0d_hsync", g), int'(hs), int'(e.hs));
                    chk($sformatf("g%0d_vsync", g), int'(vs), int'(e.vs));
                    chk($sformatf("g%0d_visible", g), int'(vis), int'(e.vis));
                    chk($sformatf("g%0d_frame_start", g), int'(fs), int'(e.fs));
                    if (fs) begin
                        if (have_start) begin
                            chk($sformatf("g%0d_frame_len", g), len, 288);
                            chk($sformatf("g%0d_hsync_cycles", g), hs_n, 36);
                            chk($sformatf("g%0d_vsync_cycles", g), vs_n, 48);
                        end
                        have_start = 1;
                        len = 0; hs_n = 0; vs_n = 0;
                    end
                    len++;
                    if (hs == HA) hs_n++;
                    if (vs == VA) vs_n++;
                end
            end
        end
    end

    initial begin
        bit found;
        found = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rgb0", int'(g_dut[0].rgb), 0);
        chk("rst_vis0", int'(g_dut[0].vis), 0);
        chk("rst_fs0",  int'(g_dut[0].fs),  0);
        chk("rst_hs0",  int'(g_dut[0].hs),  0);
        chk("rst_vs0",  int'(g_dut[0].vs),  0);
        chk("rst_rgb1", int'(g_dut[1].rgb), 0);
        chk("rst_vis1", int'(g_dut[1].vis), 0);
        chk("rst_fs1",  int'(g_dut[1].fs),  0);
        chk("rst_hs1",  int'(g_dut[1].hs),  1);
        chk("rst_vs1",  int'(g_dut[1].vs),  1);

        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2 * 288 + 20) @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (g_dut[1].mh == 20 && g_dut[1].mv == 9) begin
                found = 1;
                break;
            end
        end
        chk("wait_pos", int'(found), 1);

        // One-cycle reset in the middle of hsync and vsync.
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_addr0", int'(g_dut[0].addr), 0);
        chk("midrst_en0",   int'(g_dut[0].en),   1);
        chk("midrst_vis0",  int'(g_dut[0].vis),  0);
        chk("midrst_hs0",   int'(g_dut[0].hs),   0);
        chk("midrst_vs0",   int'(g_dut[0].vs),   0);
        chk("midrst_addr1", int'(g_dut[1].addr), 0);
        chk("midrst_en1",   int'(g_dut[1].en),   1);
        chk("midrst_vis1",  int'(g_dut[1].vis),  0);
        chk("midrst_hs1",   int'(g_dut[1].hs),   1);
        chk("midrst_vs1",   int'(g_dut[1].vs),   1);

        repeat (2 * 288 + 30) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
